test_monitor: RTL and testbench
===============================

Name: test_monitor

Overview:
- Harness-side supervisor for the self-checking test modules; it consumes their fail/finish outputs.
- Generates the held reset pulse that drives the test instances, then collects sticky per-test fail/finish status.
- Enforces a cycle timeout and presents a single registered pass/fail summary to the top-level simulation or CI wrapper.

Parameters:
- NUM_TESTS, 4: number of test instances monitored; must be >= 1.
- RESET_CYCLES, 4: cycles test_reset is held high after reset deasserts; must be >= 1.
- TIMEOUT, 1000: maximum RUN-state cycles before a forced timeout; must be >= 1.
- CNT_W, 32: width of the cycle counter; must hold TIMEOUT.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- test_fail  input  NUM_TESTS  per-test fail flag; pulse or level.
- test_finish  input  NUM_TESTS  per-test finish flag; pulse or level.
- test_reset  output  1  registered reset driven to all test instances.
- done  output  1  monitoring complete; sticky until reset.
- pass  output  1  valid when done=1: all tests finished and none failed.
- fail_mask  output  NUM_TESTS  sticky OR of test_fail sampled in RUN.
- timeout  output  1  done was caused by timeout.
- cycles  output  CNT_W  count of RUN-state clock edges.

Behaviour:
- Interface: one clock, `clock`. Reset is `reset`, synchronous and active-high. All outputs are registered.
- Reset values: state=HOLD, test_reset=1, done=0, pass=0, fail_mask=0, timeout=0, cycles=0. Internal hold counter=0 and finish_mask=0.
- HOLD state:
  - test_reset=1; test_fail and test_finish are ignored.
  - The hold counter increments on each edge with reset low.
  - On the edge where hold counter==RESET_CYCLES-1: go to RUN and set test_reset<=0.
  - test_reset is therefore high for exactly RESET_CYCLES cycles after the first cycle with reset low.
- RUN state, every edge:
  - cycles<=cycles+1.
  - fail_mask<=fail_mask|test_fail.
  - finish_mask<=finish_mask|test_finish.
  - Let fm_next=finish_mask|test_finish and fl_next=fail_mask|test_fail.
- Completion from RUN:
  - If fm_next is all ones: go to DONE with done<=1, pass<=(fl_next==0), timeout<=0.
  - Else if cycles==TIMEOUT-1: go to DONE with done<=1, pass<=0, timeout<=1.
- Simultaneous events:
  - Final finish and timeout on the same cycle: finish wins (timeout=0, pass from fail mask).
  - A fail sampled in the same cycle as the final finish is counted: pass=0 and its bit is set in fail_mask.
- DONE state:
  - All outputs are frozen and cycles stops counting.
  - test_reset stays 0 and inputs are ignored.
  - Only reset exits DONE.
- Latency: done rises on the clock edge that samples the completing condition, so it is visible the following cycle.
- Reset mid-operation, in any state: the next edge restores all reset values and HOLD restarts from count 0. Sticky masks are cleared.
- cycles value at done: the number of RUN edges including the completing edge. For example, all tests finishing in the first RUN cycle gives cycles=1.
- Width rules:
  - fail_mask and finish_mask are NUM_TESTS wide with bit i mapped to test i.
  - cycles never wraps, because RUN ends no later than TIMEOUT edges.

Optional Feature:
- Macro TEST_MONITOR_DISPLAY_EN.
- When defined: on the edge entering DONE, the block issues one $display.
  - On pass: "[test_monitor] PASS cycles:%d".
  - On fail or timeout: "[test_monitor] ~~FAIL~~ mask:%b timeout:%d cycles:%d".
  - Nothing is printed again until after the next reset.
- When undefined: no system tasks; the block is fully synthesizable. Port behaviour is identical in both cases.

Test Plan:
1. NUM_TESTS=2, RESET_CYCLES=4. Release reset, then drive test_fail=11 and test_finish=11 during HOLD -> test_reset high exactly 4 cycles; fail_mask=00; done=0 during HOLD.
2. No fails. Finish bit0 (level) at RUN cycle 2 and bit1 at RUN cycle 4 -> done=1, pass=1, fail_mask=00, timeout=0, cycles=5.
3. 1-cycle test_fail=10 pulse at RUN cycle 1. Both finish at RUN cycle 3 -> done=1, pass=0, fail_mask=10, timeout=0, cycles=4.
4. TIMEOUT=8, test1 never finishes -> done=1, timeout=1, pass=0, cycles=8. Outputs remain frozen 20 further cycles with toggling inputs.
5. TIMEOUT=8, final finish at RUN cycle 7 (cycles==7) -> timeout=0, pass=1, cycles=8. Also: a fail coinciding with the final finish -> pass=0 and the fail bit is set.
6. Assert reset for 1 cycle at RUN cycle 3 -> next cycle test_reset=1, cycles=0, fail_mask=0, done=0. A new 4-cycle HOLD follows, then normal completion.

Source files
------------

// File: rtl/test_monitor.sv
// Harness supervisor: holds test instances in reset, then gathers sticky fail/finish
// status under a cycle timeout. Define TEST_MONITOR_DISPLAY_EN for a one-shot result message.
module test_monitor #(
    parameter int unsigned NUM_TESTS    = 4,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_TESTS-1:0] test_fail,
    input  logic [NUM_TESTS-1:0] test_finish,
    output logic                 test_reset,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycles
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [NUM_TESTS-1:0] finish_mask, finish_mask_d;
    logic [NUM_TESTS-1:0] fail_mask_d;
    logic [NUM_TESTS-1:0] fm_next, fl_next;
    logic [CNT_W-1:0]     cycles_d;
    logic                 test_reset_d, done_d, pass_d, timeout_d;

    // Masks as they will look after this edge, so a same-cycle fail/finish counts
    assign fm_next = finish_mask | test_finish;
    assign fl_next = fail_mask | test_fail;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            finish_mask <= '0;
            fail_mask   <= '0;
            cycles      <= '0;
            test_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            finish_mask <= finish_mask_d;
            fail_mask   <= fail_mask_d;
            cycles      <= cycles_d;
            test_reset  <= test_reset_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        finish_mask_d = finish_mask;
        fail_mask_d   = fail_mask;
        cycles_d      = cycles;
        test_reset_d  = test_reset;
        done_d        = done;
        pass_d        = pass;
        timeout_d     = timeout;

        case (state_q)
            ST_HOLD: begin
                test_reset_d = 1'b1;
                hold_d       = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d      = ST_RUN;
                    test_reset_d = 1'b0;
                end
            end
            ST_RUN: begin
                cycles_d      = cycles + CNT_W'(1);
                fail_mask_d   = fl_next;
                finish_mask_d = fm_next;
                // Completion by finish takes priority over a coincident timeout
                if (&fm_next) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = (fl_next == '0);
                    timeout_d = 1'b0;
                end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                test_reset_d = 1'b0;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

`ifdef TEST_MONITOR_DISPLAY_EN
    // DONE is entered once per reset, so this prints at most once
    always_ff @(posedge clock) begin
        if (!reset && state_q == ST_RUN && state_d == ST_DONE) begin
            if (pass_d)
                $display("[test_monitor] PASS cycles:%d", cycles_d);
            else
                $display("[test_monitor] ~~FAIL~~ mask:%b timeout:%d cycles:%d",
                         fail_mask_d, timeout_d, cycles_d);
        end
    end
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor (2 tests, 4-cycle hold, timeout 8) with a result scoreboard.
module tb_test_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  test_fail = 2'b00;
    logic [1:0]  test_finish = 2'b00;
    logic        test_reset, done, pass, timeout;
    logic [1:0]  fail_mask;
    logic [31:0] cycles;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct packed {
        logic        pass;
        logic [1:0]  mask;
        logic        tmo;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    test_monitor #(
        .NUM_TESTS(2), .RESET_CYCLES(4), .TIMEOUT(8), .CNT_W(32)
    ) dut (
        .clock(clock), .reset(reset),
        .test_fail(test_fail), .test_finish(test_finish),
        .test_reset(test_reset), .done(done), .pass(pass),
        .fail_mask(fail_mask), .timeout(timeout), .cycles(cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set at a negedge take effect on the following posedge
    task automatic drive(input logic [1:0] f, input logic [1:0] fn);
        test_fail   = f;
        test_finish = fn;
        @(negedge clock);
    endtask

    // One reset edge, then walk the hold phase; junk toggles inputs that must be ignored
    task automatic apply_reset(input bit junk);
        int hold_cycles = 0;
        reset = 1'b1;
        test_fail = 2'b00;
        test_finish = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_test_reset", 32'(test_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_mask", 32'(fail_mask), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (!test_reset) break;
            hold_cycles++;
            if (junk) begin
                chk("hold_done", 32'(done), 32'd0);
                chk("hold_fail_mask", 32'(fail_mask), 32'd0);
                test_fail = 2'b11;
                test_finish = 2'b11;
            end
            @(negedge clock);
        end
        test_fail = 2'b00;
        test_finish = 2'b00;
        chk("hold_len", 32'(hold_cycles), 32'd4);
        chk("run_entry_cycles", cycles, 32'd0);
        chk("run_entry_mask", 32'(fail_mask), 32'd0);
        chk("run_entry_done", 32'(done), 32'd0);
    endtask

    // Wait (bounded) for done, then compare against the oldest expected result
    task automatic wait_done();
        exp_t e;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        last_exp = e;
        chk("res_pass", 32'(pass), 32'(e.pass));
        chk("res_fail_mask", 32'(fail_mask), 32'(e.mask));
        chk("res_timeout", 32'(timeout), 32'(e.tmo));
        chk("res_cycles", cycles, e.cyc);
        chk("res_test_reset", 32'(test_reset), 32'd0);
    endtask

    initial begin
        @(negedge clock);

        // Hold phase ignores inputs; then level finishes at RUN cycles 2 and 4
        apply_reset(1'b1);
        sb.push_back('{pass: 1'b1, mask: 2'b00, tmo: 1'b0, cyc: 32'd5});
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        wait_done();

        // Fail pulse on test1 at cycle 1, both finish at cycle 3
        apply_reset(1'b0);
        sb.push_back('{pass: 1'b0, mask: 2'b10, tmo: 1'b0, cyc: 32'd4});
        drive(2'b00, 2'b00);
        drive(2'b10, 2'b00);
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b11);
        test_finish = 2'b00;
        wait_done();

        // Test1 never finishes: timeout, then outputs frozen under toggling inputs
        apply_reset(1'b0);
        sb.push_back('{pass: 1'b0, mask: 2'b00, tmo: 1'b1, cyc: 32'd8});
        test_finish = 2'b01;
        wait_done();
        for (int i = 0; i < 20; i++) begin
            drive(2'($urandom), 2'($urandom));
            chk("frz_done", 32'(done), 32'd1);
            chk("frz_pass", 32'(pass), 32'(last_exp.pass));
            chk("frz_fail_mask", 32'(fail_mask), 32'(last_exp.mask));
            chk("frz_timeout", 32'(timeout), 32'(last_exp.tmo));
            chk("frz_cycles", cycles, last_exp.cyc);
            chk("frz_test_reset", 32'(test_reset), 32'd0);
        end

        // Final finish on the timeout cycle: finish wins
        apply_reset(1'b0);
        sb.push_back('{pass: 1'b1, mask: 2'b00, tmo: 1'b0, cyc: 32'd8});
        for (int k = 0; k < 7; k++) drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        test_finish = 2'b00;
        wait_done();

        // Fail coinciding with the final finish on the timeout cycle
        apply_reset(1'b0);
        sb.push_back('{pass: 1'b0, mask: 2'b01, tmo: 1'b0, cyc: 32'd8});
        for (int k = 0; k < 7; k++) drive(2'b00, 2'b01);
        drive(2'b01, 2'b11);
        test_fail = 2'b00;
        test_finish = 2'b00;
        wait_done();

        // Reset mid-RUN clears sticky state; then finish on the very first RUN cycle
        apply_reset(1'b0);
        drive(2'b01, 2'b01);
        drive(2'b00, 2'b00);
        drive(2'b00, 2'b00);
        chk("pre_reset_mask", 32'(fail_mask), 32'd1);
        chk("pre_reset_cycles", cycles, 32'd3);
        apply_reset(1'b0);
        sb.push_back('{pass: 1'b1, mask: 2'b00, tmo: 1'b0, cyc: 32'd1});
        drive(2'b00, 2'b11);
        test_finish = 2'b00;
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
